// File: rtl/rgmii_rx_assembler.sv
// rtl/rgmii_rx_assembler.sv - RGMII receive DDR samples to GMII byte stream, 10/100/1000M.
// Optional in-band link status decode when RGMII_RX_INBAND_STATUS_EN is defined.
module rgmii_rx_assembler #(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               q1,
  input  logic [4:0]               q2,
  input  logic [1:0]               speed,
  output logic [7:0]               gmii_rxd,
  output logic                     gmii_rx_dv,
  output logic                     gmii_rx_er,
  output logic                     gmii_rx_valid,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     link_up,
  output logic [1:0]               link_speed,
  output logic                     full_duplex
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, BYTE} state_t;

  state_t                   state_q;
  logic [1:0]               spd_q;
  logic [1:0]               spd_d;
  logic [3:0]               low_q;
  logic                     er_low_q;
  logic                     ferr_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_d;
  logic [7:0]               rxd_q;
  logic                     dv_q;
  logic                     er_q;
  logic                     valid_q;
  logic                     dv_in;
  logic                     er_in;
  logic                     gig;

  // Speed follows the pin only between frames; mid-frame the latched value rules.
  always_comb begin
    spd_d     = (state_q == IDLE) ? speed : spd_q;
    gig       = spd_d[1];
    dv_in     = q1[4];
    er_in     = q1[4] ^ q2[4];
    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      spd_q     <= 2'b10;
      low_q     <= 4'h0;
      er_low_q  <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
      rxd_q     <= 8'h00;
      dv_q      <= 1'b0;
      er_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      spd_q   <= spd_d;
      valid_q <= 1'b0;
      if (gig) begin
        rxd_q   <= {q2[3:0], q1[3:0]};
        dv_q    <= dv_in;
        er_q    <= er_in;
        valid_q <= 1'b1;
        if (dv_in) begin
          state_q <= BYTE;
          ferr_q  <= ((state_q == BYTE) & ferr_q) | er_in;
        end else begin
          state_q <= IDLE;
          ferr_q  <= 1'b0;
          if (state_q == BYTE && ferr_q) err_cnt_q <= err_cnt_d;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (dv_in) begin
              low_q    <= q1[3:0];
              er_low_q <= er_in;
              ferr_q   <= 1'b0;
              state_q  <= LOW;
            end
          end
          LOW: begin
            dv_q    <= 1'b1;
            valid_q <= 1'b1;
            if (dv_in) begin
              rxd_q   <= {q1[3:0], low_q};
              er_q    <= er_low_q | er_in;
              ferr_q  <= ferr_q | er_low_q | er_in;
              state_q <= HIGH;
            end else begin
              // Odd nibble count: flush the orphan nibble as an errored byte.
              rxd_q     <= {4'h0, low_q};
              er_q      <= 1'b1;
              ferr_q    <= 1'b0;
              err_cnt_q <= err_cnt_d;
              state_q   <= IDLE;
            end
          end
          HIGH: begin
            if (dv_in) begin
              low_q    <= q1[3:0];
              er_low_q <= er_in;
              state_q  <= LOW;
            end else begin
              if (ferr_q) err_cnt_q <= err_cnt_d;
              ferr_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gmii_rxd      = rxd_q;
  assign gmii_rx_dv    = dv_q;
  assign gmii_rx_er    = er_q;
  assign gmii_rx_valid = valid_q;
  assign err_cnt       = err_cnt_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
  logic [3:0] samp_q;
  logic       samp_vld_q;
  logic       link_q;
  logic [1:0] lspd_q;
  logic       dup_q;

  // A status value is accepted only after two identical back-to-back idle samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q     <= 4'h0;
      samp_vld_q <= 1'b0;
      link_q     <= 1'b0;
      lspd_q     <= 2'b00;
      dup_q      <= 1'b0;
    end else if (!dv_in && !er_in) begin
      samp_q     <= q1[3:0];
      samp_vld_q <= 1'b1;
      if (samp_vld_q && samp_q == q1[3:0]) begin
        link_q <= q1[0];
        lspd_q <= q1[2:1];
        dup_q  <= q1[3];
      end
    end else begin
      samp_vld_q <= 1'b0;
    end
  end

  assign link_up     = link_q;
  assign link_speed  = lspd_q;
  assign full_duplex = dup_q;
`else
  assign link_up     = 1'b1;
  assign link_speed  = spd_q;
  assign full_duplex = 1'b1;
`endif

endmodule
